// File: rtl/serial_host_ctrl.sv
// serial_host_ctrl: initiator end of the single-wire daisychain link.
// Frames one operation at a time as: start bit, command (MSB first), gap,
// then a write payload, or a turnaround followed by a read payload.
// Handshake: an operation is taken on a rising clk edge where req && ready;
// op and tx_data are captured only on that edge. While ready is low, req is
// ignored and nothing is queued.
// The host drives the line at all times except TURN and RX_DATA. All outputs
// are registered, so the line trails the state register by one cycle.
module serial_host_ctrl #(
  parameter int                DATA_LEN     = 8,
  parameter int                CMD_LEN      = 2,
  parameter logic [CMD_LEN-1:0] CMD_SND_CODE = CMD_LEN'(2'b01),
  parameter logic [CMD_LEN-1:0] CMD_RCV_CODE = CMD_LEN'(2'b10),
  parameter logic [CMD_LEN-1:0] CMD_RST_CODE = CMD_LEN'(2'b11),
  parameter logic [CMD_LEN-1:0] CMD_UPD_CODE = CMD_LEN'(2'b00),
  parameter int                GAP_LEN      = 2,
  parameter int                TURN_LEN     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic [1:0]          op,
  input  logic [DATA_LEN-1:0] tx_data,
  output logic                ready,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                done,
  inout  wire                 data_inout,
  output logic [2:0]          state_debug,
  output logic                drive_en_debug
);

  localparam int MAX_A   = (DATA_LEN > CMD_LEN) ? DATA_LEN : CMD_LEN;
  localparam int MAX_B   = (GAP_LEN > TURN_LEN) ? GAP_LEN : TURN_LEN;
  localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LEN - 1);

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_RESET  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_CMD     = 3'd2,
    S_GAP     = 3'd3,
    S_TX_DATA = 3'd4,
    S_TURN    = 3'd5,
    S_RX_DATA = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t               state, state_next, after_gap, after_cmd;
  logic [CNT_W-1:0]     cnt;
  logic [1:0]           op_q;
  logic [CMD_LEN-1:0]   cmd_sr, cmd_map;
  logic [DATA_LEN-1:0]  tx_sr, rx_sr;
  logic                 line_q, drive_q, accept;

  assign accept         = req && ready && (state == S_IDLE);
  assign data_inout     = drive_q ? line_q : 1'bz;
  assign state_debug    = state;
  assign drive_en_debug = drive_q;

  // Map the requested operation to the command code sent to the responder.
  always_comb begin
    cmd_map = CMD_UPD_CODE;
    case (op)
      OP_WRITE: cmd_map = CMD_RCV_CODE;
      OP_READ:  cmd_map = CMD_SND_CODE;
      OP_RESET: cmd_map = CMD_RST_CODE;
      default:  cmd_map = CMD_UPD_CODE;
    endcase
  end

  // Next-state logic; zero-length gap/turn phases are skipped entirely.
  always_comb begin
    after_gap = S_DONE;
    if (op_q == OP_WRITE)     after_gap = S_TX_DATA;
    else if (op_q == OP_READ) after_gap = (TURN_LEN > 0) ? S_TURN : S_RX_DATA;
    after_cmd  = (GAP_LEN > 0) ? S_GAP : after_gap;
    state_next = state;
    case (state)
      S_IDLE:    if (accept) state_next = S_START;
      S_START:   state_next = S_CMD;
      S_CMD:     if (cnt == CMD_LAST)  state_next = after_cmd;
      S_GAP:     if (cnt == GAP_LAST)  state_next = after_gap;
      S_TX_DATA: if (cnt == DATA_LAST) state_next = S_DONE;
      S_TURN:    if (cnt == TURN_LAST) state_next = S_RX_DATA;
      S_RX_DATA: if (cnt == DATA_LAST) state_next = S_DONE;
      default:   state_next = S_IDLE;
    endcase
  end

  // State register and phase bit counter (cleared on every state change).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || state == S_IDLE || state == S_START || state == S_DONE)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Shadow registers: capture on accept, shift MSB-out / LSB-in per phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q   <= '0;
      cmd_sr <= '0;
      tx_sr  <= '0;
      rx_sr  <= '0;
    end else begin
      if (accept) begin
        op_q   <= op;
        tx_sr  <= tx_data;
        cmd_sr <= cmd_map;
      end
      if (state == S_CMD)     cmd_sr <= cmd_sr << 1;
      if (state == S_TX_DATA) tx_sr  <= tx_sr << 1;
      if (state == S_RX_DATA) rx_sr  <= {rx_sr[DATA_LEN-2:0], data_inout};
    end
  end

  // Registered outputs: line value, drive enable, status pulses and read result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      line_q   <= 1'b0;
      drive_q  <= 1'b1;
      ready    <= 1'b1;
      done     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      ready    <= (state == S_IDLE) && !accept;
      done     <= (state == S_DONE);
      rx_valid <= (state == S_DONE) && (op_q == OP_READ);
      if (state == S_DONE && op_q == OP_READ) rx_data <= rx_sr;
      drive_q  <= 1'b1;
      line_q   <= 1'b0;
      case (state)
        S_START:   line_q  <= 1'b1;
        S_CMD:     line_q  <= cmd_sr[CMD_LEN-1];
        S_TX_DATA: line_q  <= tx_sr[DATA_LEN-1];
        S_TURN:    drive_q <= 1'b0;
        S_RX_DATA: drive_q <= 1'b0;
        default:   line_q  <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_host_ctrl.sv
// Bench for serial_host_ctrl: table of whole-frame vectors plus hand-written
// sequences for reset mid-frame and req held while busy.
module tb_serial_host_ctrl;

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_RESET  = 2'd2;
  localparam logic [1:0] OP_UPDATE = 2'd3;
  localparam logic [1:0] SND = 2'b01, RCV = 2'b10, RST = 2'b11, UPD = 2'b00;

  logic       clk = 1'b0;
  logic       reset, req;
  logic [1:0] op;
  logic [7:0] tx_data, rx_data;
  logic       ready, rx_valid, done, drive_en_debug;
  logic [2:0] state_debug;
  logic       tb_drv_en, tb_drv_val;
  wire        data_inout;

  assign data_inout = tb_drv_en ? tb_drv_val : 1'bz;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] last_rx = 8'h00;

  typedef struct {
    logic [1:0] op;
    logic [7:0] tx;
    logic [7:0] rx_in;
  } vec_t;

  vec_t vecs[6];

  serial_host_ctrl #(
    .DATA_LEN(8), .CMD_LEN(2),
    .CMD_SND_CODE(SND), .CMD_RCV_CODE(RCV), .CMD_RST_CODE(RST), .CMD_UPD_CODE(UPD),
    .GAP_LEN(2), .TURN_LEN(1)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .tx_data(tx_data),
    .ready(ready), .rx_data(rx_data), .rx_valid(rx_valid), .done(done),
    .data_inout(data_inout), .state_debug(state_debug), .drive_en_debug(drive_en_debug)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] code_of(input logic [1:0] o);
    case (o)
      OP_WRITE: return RCV;
      OP_READ:  return SND;
      OP_RESET: return RST;
      default:  return UPD;
    endcase
  endfunction

  // Issue one operation and check every line cycle until ready returns.
  task automatic run_op(input logic [1:0] o, input logic [7:0] tx, input logic [7:0] rx_in,
                        input bit hold_req);
    int guard = 0;
    int done_at;
    logic [1:0] c;
    logic exp_drv, exp_val;
    c = code_of(o);
    done_at = (o == OP_READ) ? 15 : (o == OP_WRITE) ? 14 : 6;
    while (ready !== 1'b1 && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 40) begin
      check("ready_wait_timeout", 8'(ready), 8'h1);
      return;
    end
    req = 1'b1; op = o; tx_data = tx;
    @(posedge clk); #1;
    check("ready_after_accept", 8'(ready), 8'h0);
    if (hold_req) begin
      op = OP_WRITE; tx_data = 8'h11;
    end else begin
      req = 1'b0; op = 2'($urandom_range(0, 3)); tx_data = 8'($urandom_range(0, 255));
    end
    for (int k = 1; k <= done_at; k++) begin
      @(posedge clk); #1;
      exp_drv = 1'b1; exp_val = 1'b0;
      if (k == 1) exp_val = 1'b1;
      else if (k <= 3) exp_val = c[3-k];
      else if (k <= 5) exp_val = 1'b0;
      else if (o == OP_WRITE && k <= 13) exp_val = tx[13-k];
      else if (o == OP_READ && k <= 14) exp_drv = 1'b0;
      check("drive_en", 8'(drive_en_debug), 8'(exp_drv));
      if (exp_drv) check("line", 8'(data_inout), 8'(exp_val));
      check("done", 8'(done), 8'(k == done_at));
      check("ready_busy", 8'(ready), 8'h0);
      if (o == OP_READ && k == done_at) begin
        last_rx = rx_in;
        check("rx_valid_pulse", 8'(rx_valid), 8'h1);
      end else begin
        check("rx_valid_low", 8'(rx_valid), 8'h0);
      end
      check("rx_data", rx_data, last_rx);
      if (o == OP_READ && k >= 6 && k <= 13) begin
        tb_drv_en = 1'b1; tb_drv_val = rx_in[13-k];
      end else begin
        tb_drv_en = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("done_end", 8'(done), 8'h0);
    check("ready_end", 8'(ready), 8'h1);
    check("line_end", 8'(data_inout), 8'h0);
  endtask

  initial begin
    vecs[0] = '{OP_WRITE,  8'hA5, 8'h00};
    vecs[1] = '{OP_READ,   8'h00, 8'h3C};
    vecs[2] = '{OP_UPDATE, 8'h00, 8'h00};
    vecs[3] = '{OP_RESET,  8'h00, 8'h00};
    vecs[4] = '{OP_READ,   8'hFF, 8'hC3};
    vecs[5] = '{OP_WRITE,  8'h5A, 8'h00};

    reset = 1'b0; req = 1'b0; op = 2'd0; tx_data = 8'h00;
    tb_drv_en = 1'b0; tb_drv_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_line", 8'(data_inout), 8'h0);
    check("rst_drive", 8'(drive_en_debug), 8'h1);
    check("rst_ready", 8'(ready), 8'h1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_done", 8'(done), 8'h0);
    check("rst_rx_valid", 8'(rx_valid), 8'h0);
    check("rst_state", 8'(state_debug), 8'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Table: write, read, update/reset back-to-back, read, write
    for (int i = 0; i < 6; i++) run_op(vecs[i].op, vecs[i].tx, vecs[i].rx_in, 1'b0);

    // Reset during the fourth data bit of a write
    req = 1'b1; op = OP_WRITE; tx_data = 8'h5A;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    last_rx = 8'h00;
    check("midrst_state", 8'(state_debug), 8'h0);
    check("midrst_line", 8'(data_inout), 8'h0);
    check("midrst_drive", 8'(drive_en_debug), 8'h1);
    check("midrst_done", 8'(done), 8'h0);
    check("midrst_ready", 8'(ready), 8'h1);
    check("midrst_rx_data", rx_data, 8'h00);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check("midrst_no_done", 8'(done), 8'h0);
      check("midrst_idle", 8'(state_debug), 8'h0);
    end
    run_op(OP_WRITE, 8'hFF, 8'h00, 1'b0);

    // req held with op=WRITE during a read: taken only once ready returns
    run_op(OP_READ, 8'h00, 8'h96, 1'b1);
    run_op(OP_WRITE, 8'h11, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

endmodule
